// File: rtl/round_key_sequencer.sv
// ---------------------------------------------------------------------------
// round_key_sequencer
//
// Purpose:
//   Walks the expanded round-key memory of the key expansion block and
//   streams the round keys to the cipher round datapath over a valid/ready
//   handshake.
//   - Encryption: keys go out in forward order (address 0..Nr).
//   - Decryption: keys go out in reverse order (address Nr..0).
//   A stream starts only while key expansion reports ready.
//
// Optional feature (macro INV_MIXCOL_KEY_EN):
//   When defined and the latched decrypt flag is set, keys for rounds
//   1..Nr-1 pass through InvMixColumns before they reach rk_data. This
//   supports the equivalent inverse cipher. Rounds 0 and Nr, and all
//   encrypt keys, always pass raw. When undefined, rk_data is always the raw
//   memory word.
//
// Ports:
//   clk       in   1    system clock, rising edge
//   reset     in   1    synchronous active-high reset
//   aes_mode  in   2    01 AES-128, 10 AES-192, 11 AES-256, 00 as AES-128
//   decrypt   in   1    1 = reverse key order
//   start     in   1    single-cycle request to begin a key stream
//   key_rdy   in   1    key memory valid; low while busy aborts the stream
//   rkey_addr out  4    round-key memory address (registered)
//   rkey      in   128  memory read data, one cycle after rkey_addr
//   rk_valid  out  1    rk_data holds a valid key
//   rk_ready  in   1    consumer accepts the key
//   rk_data   out  128  round key, column 0 = [127:96]
//   rk_round  out  4    round index 0..Nr
//   rk_last   out  1    high with the key for round Nr
//   busy      out  1    stream in progress
// ---------------------------------------------------------------------------
module round_key_sequencer (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   aes_mode,
  input  logic         decrypt,
  input  logic         start,
  input  logic         key_rdy,
  output logic [3:0]   rkey_addr,
  input  logic [127:0] rkey,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_LOAD    = 2'd2,
    S_PRESENT = 2'd3
  } state_t;

  state_t       state_reg;
  state_t       state_next;

  logic [3:0]   nr_reg;     // Nr latched at start
  logic         dec_reg;    // decrypt latched at start
  logic [3:0]   idx_reg;    // sequence index of the key being fetched

  logic         accept;
  logic         abort;
  logic         load;
  logic         handshake;
  logic         is_last;
  logic [127:0] key_word;

  function automatic logic [3:0] nr_of(input logic [1:0] mode);
    case (mode)
      2'b10:   return 4'd12;
      2'b11:   return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

`ifdef INV_MIXCOL_KEY_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by one of the InvMixColumns coefficients (09, 0b, 0d, 0e).
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    case (k)
      4'd9:    return x8 ^ b;
      4'd11:   return x8 ^ x2 ^ b;
      4'd13:   return x8 ^ x4 ^ b;
      4'd14:   return x8 ^ x4 ^ x2;
      default: return b;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9),
            gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13),
            gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11),
            gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14)};
  endfunction

  logic [127:0] imc_word;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_imc
      assign imc_word[127-32*gi -: 32] = inv_mix_col(rkey[127-32*gi -: 32]);
    end
  endgenerate
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; losing key_rdy outside IDLE always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (start && key_rdy) state_next = S_WAIT;
      S_WAIT:    state_next = S_LOAD;
      S_LOAD:    state_next = S_PRESENT;
      S_PRESENT: if (rk_ready) state_next = rk_last ? S_IDLE : S_LOAD;
      default:   state_next = S_IDLE;
    endcase
    if (state_reg != S_IDLE && !key_rdy) begin
      state_next = S_IDLE;
    end
  end

  // Output/control decode driving the datapath registers
  always_comb begin
    accept    = (state_reg == S_IDLE) && start && key_rdy;
    abort     = (state_reg != S_IDLE) && !key_rdy;
    load      = (state_reg == S_LOAD) && key_rdy;
    handshake = (state_reg == S_PRESENT) && rk_ready && key_rdy;
    is_last   = (idx_reg == nr_reg);
    key_word  = rkey;
`ifdef INV_MIXCOL_KEY_EN
    // Middle decrypt rounds only; the first and last decrypt keys stay raw.
    if (dec_reg && (idx_reg != 4'd0) && !is_last) begin
      key_word = imc_word;
    end
`endif
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rkey_addr <= 4'd0;
      rk_valid  <= 1'b0;
      rk_data   <= 128'd0;
      rk_round  <= 4'd0;
      rk_last   <= 1'b0;
      busy      <= 1'b0;
      nr_reg    <= 4'd10;
      dec_reg   <= 1'b0;
      idx_reg   <= 4'd0;
    end else if (accept) begin
      nr_reg    <= nr_of(aes_mode);
      dec_reg   <= decrypt;
      rkey_addr <= decrypt ? nr_of(aes_mode) : 4'd0;
      idx_reg   <= 4'd0;
      busy      <= 1'b1;
    end else if (abort) begin
      // Data, round and address are deliberately left as they were.
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      busy     <= 1'b0;
    end else if (load) begin
      rk_data  <= key_word;
      rk_round <= idx_reg;
      rk_last  <= is_last;
      rk_valid <= 1'b1;
      // Prefetch the next key so PRESENT->LOAD needs no extra wait state.
      if (!is_last) begin
        rkey_addr <= dec_reg ? (rkey_addr - 4'd1) : (rkey_addr + 4'd1);
      end
    end else if (handshake) begin
      rk_valid <= 1'b0;
      rk_last  <= 1'b0;
      if (rk_last) begin
        busy <= 1'b0;
      end else begin
        idx_reg <= idx_reg + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_round_key_sequencer.sv
module tb_round_key_sequencer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [1:0]   aes_mode = 2'b01;
  logic         decrypt = 1'b0;
  logic         start = 1'b0;
  logic         key_rdy = 1'b0;
  logic [3:0]   rkey_addr;
  logic [127:0] rkey;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         busy;

  round_key_sequencer dut (
    .clk(clk), .reset(reset), .aes_mode(aes_mode), .decrypt(decrypt),
    .start(start), .key_rdy(key_rdy), .rkey_addr(rkey_addr), .rkey(rkey),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_round(rk_round), .rk_last(rk_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_cyc = 0;
  int first_rel = -1;
  int last_round_seen = -1;
  int stall_round = -1;
  int stall_left = 0;
  bit rand_ready = 1'b0;
  logic [127:0] obs_data [16];

  always @(posedge clk) cyc <= cyc + 1;

  // Round-key memory stub with registered read
  logic [127:0] mem [16];
  always @(posedge clk) rkey <= mem[rkey_addr];

  typedef struct {
    logic [127:0] data;
    int           round;
    bit           last;
  } exp_t;
  exp_t exp_q[$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input int k);
    case (k)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  // Inverse MixColumns as a matrix product over GF(2^8)
  function automatic logic [127:0] imc128(input logic [127:0] w);
    logic [127:0] r;
    logic [7:0]   acc;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(coef((k - row + 4) % 4), w[127 - 32*c - 8*k -: 8]);
        end
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic int nr_model(input logic [1:0] mode);
    return (mode == 2'b10) ? 12 : (mode == 2'b11) ? 14 : 10;
  endfunction

  task automatic push_stream(input logic [1:0] mode, input bit dec);
    int   nr;
    exp_t e;
    nr = nr_model(mode);
    for (int i = 0; i <= nr; i++) begin
      e.data = mem[dec ? (nr - i) : i];
`ifdef INV_MIXCOL_KEY_EN
      if (dec && i != 0 && i != nr) e.data = imc128(e.data);
`endif
      e.round = i;
      e.last  = (i == nr);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && rk_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key actual round=%0d data=%h required no key", rk_round, rk_data);
      end else begin
        if (first_rel < 0) first_rel = cyc - s_cyc;
        if (rk_data !== exp_q[0].data || int'(rk_round) != exp_q[0].round || rk_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL key_r%0d actual data=%h round=%0d last=%0d required data=%h round=%0d last=%0d",
                   exp_q[0].round, rk_data, rk_round, rk_last, exp_q[0].data, exp_q[0].round, exp_q[0].last);
        end
        if (rk_ready) begin
          obs_data[rk_round] = rk_data;
          if (rk_last) last_round_seen = int'(rk_round);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && rk_valid && int'(rk_round) == stall_round) begin
        rk_ready = 1'b0;
        stall_left--;
      end else begin
        rk_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic begin_stream(input logic [1:0] mode, input bit dec);
    aes_mode = mode;
    decrypt  = dec;
    start    = 1'b1;
    push_stream(mode, dec);
    s_cyc = cyc;
    first_rel = -1;
    last_round_seen = -1;
    for (int i = 0; i < 16; i++) obs_data[i] = '0;
    tick();
    start = 1'b0;
    check("busy_after_start", 128'(busy), 128'd1);
  endtask

  task automatic wait_done(input int exp_end);
    int rel;
    rel = -1;
    for (int n = 0; n < 400; n++) begin
      if (!busy) begin
        rel = cyc - s_cyc;
        break;
      end
      tick();
    end
    if (rel < 0) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout actual=busy required=idle within 400 cycles");
    end else if (exp_end >= 0) begin
      check("stream_end_cycle", 128'(rel), 128'(exp_end));
    end
    check("keys_outstanding", 128'(exp_q.size()), 128'd0);
    check("first_valid_cycle", 128'(first_rel), 128'd3);
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_rkey_addr", 128'(rkey_addr), 128'd0);
    check("rst_rk_valid", 128'(rk_valid), 128'd0);
    check("rst_rk_data", rk_data, 128'd0);
    check("rst_rk_round", 128'(rk_round), 128'd0);
    check("rst_rk_last", 128'(rk_last), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_random();
    repeat (3) tick();
    check_reset_values();
    reset = 1'b0;
    key_rdy = 1'b1;
    tick();

    // AES-128 encrypt, FIPS-197 key schedule of 2b7e151628aed2a6abf7158809cf4f3c
    mem[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    mem[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    mem[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    mem[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    mem[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    mem[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    mem[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    mem[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    mem[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    mem[9]  = 128'hac7766f319fadc2128d12941575c006e;
    mem[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    begin_stream(2'b01, 1'b0);
    wait_done(24);
    check("aes128_round0", obs_data[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("aes128_round10", obs_data[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("aes128_last_round", 128'(last_round_seen), 128'd10);

    // AES-256 decrypt
    fill_random();
    mem[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
    mem[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
    mem[14] = 128'hfe4890d1e6188d0b046df344706c631e;
    begin_stream(2'b11, 1'b1);
    wait_done(32);
    check("aes256_dec_first", obs_data[0], 128'hfe4890d1e6188d0b046df344706c631e);
    check("aes256_dec_last_round", 128'(last_round_seen), 128'd14);
    check("aes256_dec_last_key", obs_data[14], 128'h603deb1015ca71be2b73aef0857d7781);
`ifndef INV_MIXCOL_KEY_EN
    check("aes256_dec_round13", obs_data[13], 128'h1f352c073b6108d72d9810a30914dff4);
`endif

    // Backpressure: 4 stall cycles on round 2
    fill_random();
    stall_round = 2;
    stall_left = 4;
    begin_stream(2'b01, 1'b0);
    wait_done(28);
    check("stall_consumed", 128'(stall_left), 128'd0);
    stall_round = -1;

    // start while key_rdy low is ignored
    key_rdy = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_no_keyrdy_busy", 128'(busy), 128'd0);
    tick();
    check("start_no_keyrdy_valid", 128'(rk_valid), 128'd0);
    key_rdy = 1'b1;
    tick();

    // second start while busy is ignored
    fill_random();
    begin_stream(2'b01, 1'b0);
    repeat (3) tick();
    aes_mode = 2'b11;
    decrypt = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(24);

    // abort by dropping key_rdy at round 5
    fill_random();
    begin_stream(2'b01, 1'b0);
    begin
      logic [127:0] held;
      int n;
      n = 0;
      while (!(rk_valid && rk_round == 4'd5) && n < 100) begin
        tick();
        n++;
      end
      check("abort_reached_r5", 128'(rk_round), 128'd5);
      held = rk_data;
      key_rdy = 1'b0;
      tick();
      check("abort_valid", 128'(rk_valid), 128'd0);
      check("abort_busy", 128'(busy), 128'd0);
      check("abort_last", 128'(rk_last), 128'd0);
      check("abort_round_kept", 128'(rk_round), 128'd5);
      check("abort_data_kept", rk_data, held);
    end
    exp_q.delete();
    key_rdy = 1'b1;
    tick();

    // reset mid-stream
    fill_random();
    begin_stream(2'b10, 1'b1);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    exp_q.delete();
    tick();

    // mode 00 acts as AES-128; later mode change has no effect
    fill_random();
    begin_stream(2'b00, 1'b0);
    repeat (5) tick();
    aes_mode = 2'b11;
    wait_done(24);
    check("mode00_last_round", 128'(last_round_seen), 128'd10);

`ifdef INV_MIXCOL_KEY_EN
    fill_random();
    mem[5] = {4{32'h8e4da1bc}};
    begin_stream(2'b01, 1'b1);
    wait_done(24);
    check("imc_round5", obs_data[5], {4{32'hdb135345}});
    check("imc_round0_raw", obs_data[0], mem[10]);
    check("imc_round10_raw", obs_data[10], mem[0]);
`endif

    // randomized streams, some with random backpressure
    for (int t = 0; t < 10; t++) begin
      logic [1:0] m;
      bit d;
      fill_random();
      m = 2'($urandom_range(0, 3));
      d = 1'($urandom_range(0, 1));
      rand_ready = (t % 2 == 1);
      begin_stream(m, d);
      wait_done(rand_ready ? -1 : 2 * (nr_model(m) + 1) + 2);
      rand_ready = 1'b0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
# round_key_sequencer

Reads the expanded round-key memory of the key expansion block by driving its `rkey_addr` port, and streams round keys to the cipher round datapath over a valid/ready handshake. Keys go out in forward order for encryption (0..Nr) and reverse order for decryption (Nr..0). The block sits between the key expansion block and the round controller. It starts only once key expansion reports ready.

## Interface

Parameters:
- none; key count is derived from `aes_mode`.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `aes_mode`  in  2  key size: 01 = AES-128 (Nr=10), 10 = AES-192 (Nr=12), 11 = AES-256 (Nr=14), 00 = treated as AES-128.
- `decrypt`  in  1  1 = reverse key order.
- `start`  in  1  single-cycle request to begin a key stream.
- `key_rdy`  in  1  ready flag from key expansion; memory contents are valid while high.
- `rkey_addr`  out  4  round-key memory address, registered.
- `rkey`  in  128  memory read data, valid one cycle after `rkey_addr` changes (registered read).
- `rk_valid`  out  1  `rk_data` holds a valid key.
- `rk_ready`  in  1  consumer accepts the key.
- `rk_data`  out  128  round key; column 0 = [127:96], byte 0 = [127:120].
- `rk_round`  out  4  sequence index 0..Nr, i.e. the round in which the key is used.
- `rk_last`  out  1  high with the key where `rk_round`==Nr.
- `busy`  out  1  high from `start` acceptance until the final handshake or an abort.

## Operation

- FSM states: IDLE, WAIT, LOAD, PRESENT.
- IDLE:
  - `start`=1 and `key_rdy`=1: latch `aes_mode` and `decrypt`, set `rkey_addr` to 0 (encrypt) or Nr (decrypt), clear the index, assert `busy`, go to WAIT.
  - `start` with `key_rdy`=0: ignored.
- WAIT: always go to LOAD. This state covers memory read latency.
- LOAD: `rk_data` <= `rkey` (transformed, see Configuration). Set `rk_round` from the index, set `rk_last` = (index==Nr), `rk_valid` <= 1. Advance `rkey_addr` by ±1 unless this key is the last. Go to PRESENT.
- PRESENT: hold `rk_valid`, `rk_data`, `rk_round` and `rk_last` stable until `rk_ready`=1. On the handshake:
  - `rk_valid` <= 0.
  - If last: `busy` <= 0, go to IDLE.
  - Otherwise: index+1, go to LOAD. The next address is already latched, so no WAIT is needed.
- `aes_mode` and `decrypt` changes after acceptance have no effect until the next `start`.
- `start` while `busy`: ignored.
- `rk_ready` while `rk_valid`=0: no effect.
- Abort: `key_rdy`=0 in any non-IDLE state forces IDLE at the next edge. `rk_valid`, `rk_last` and `busy` go to 0; `rk_data`, `rk_round` and `rkey_addr` keep their values.
- Reset (including mid-stream) forces IDLE.
- Reset values: `rkey_addr`=0, `rk_valid`=0, `rk_data`=0, `rk_round`=0, `rk_last`=0, `busy`=0.

## Timing

- `start` sampled high at edge E0 → `busy` high in the cycle after E0. `rk_valid` first goes high after E2, i.e. 3-cycle latency.
- Steady state with `rk_ready`=1: one key per 2 cycles. `rk_valid` is low for one cycle between keys.
- AES-128, ready always high: 11 keys, valid during cycles 3, 5, …, 23. `busy` falls after the E23 handshake.
- AES-256: 15 keys; the last key is valid at cycle 31.
- Each stall cycle with `rk_ready`=0 in PRESENT adds one cycle.
- A new `start` is accepted in the cycle after `busy` falls.

## Configuration

- Macro: `INV_MIXCOL_KEY_EN`.
- Defined, with latched `decrypt`=1: keys with `rk_round` 1..Nr-1 are passed through InvMixColumns (per column, standard GF(2^8) matrix 0e/0b/0d/09) before loading `rk_data`. This serves the equivalent inverse cipher. Rounds 0 and Nr and all encrypt keys pass raw. Latency is unchanged because the transform is combinational ahead of the `rk_data` register.
- Undefined: `rk_data` always equals the raw `rkey`.

## Test plan

- AES-128 encrypt, memory model loaded from key expansion of key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - Addresses 0..10 in order; `rk_round` 0..10.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last`=1.
  - First `rk_valid` at cycle 3.
- AES-256 decrypt, key 603deb10…0914dff4:
  - First key fe4890d1e6188d0b046df344706c631e (address 14); `rk_last` on address 0.
  - Round 13 is 1f352c073b6108d72d9810a30914dff4 when the macro is undefined.
- Backpressure: hold `rk_ready`=0 for 4 cycles on round 2 → `rk_data` and `rk_round` stable and `rk_valid` high throughout; stream completes 4 cycles late.
- Boundaries:
  - `start` with `key_rdy`=0 → `busy` stays 0.
  - Second `start` while busy → ignored.
  - Drop `key_rdy` at round 5 → `rk_valid` and `busy` are 0 next cycle.
  - Assert `reset` mid-stream → all outputs at reset values next cycle.
- `INV_MIXCOL_KEY_EN` defined, decrypt, AES-128, memory stub word 8e4da1bc repeated at address 5 → `rk_data` db135345 repeated. Addresses 0 and 10 are output raw.
- `aes_mode`=00 → 11 keys; change `aes_mode` to 11 mid-stream → still 11 keys.
